// File: rtl/ct_had_event_sync_if.sv
// Multi-channel debug-event boundary between HAD and the trace/ETM domain, with clock-enable generation.
// Define HAD_EVT_OVF_DET_EN to build the sticky per-channel overflow detectors.
module ct_had_event_sync_if #(
    parameter int CH_NUM     = 4,
    parameter int SYNC_STAGE = 2,
    parameter int IDLE_HOLD  = 3
) (
    input  logic              event_clk,
    input  logic              cpurst_b,
    input  logic [CH_NUM-1:0] x_evt_in,
    output logic [CH_NUM-1:0] x_evt_in_sync,
    output logic [CH_NUM-1:0] x_evt_in_pulse,
    input  logic [CH_NUM-1:0] x_evt_out,
    output logic [CH_NUM-1:0] x_evt_out_ff,
    output logic [CH_NUM-1:0] x_evt_out_pend,
    input  logic [CH_NUM-1:0] x_evt_out_ack,
    output logic [CH_NUM-1:0] x_evt_ovf,
    input  logic              x_ovf_clr,
    output logic              x_event_clk_en
);

    localparam logic [3:0] HOLD_INIT = 4'(IDLE_HOLD);

    logic [CH_NUM-1:0] sync_q [SYNC_STAGE];
    logic [CH_NUM-1:0] in_prev;
    logic [CH_NUM-1:0] sync_any;
    logic [CH_NUM-1:0] out_rise;
    logic [3:0]        hold_cnt;
    logic              act;

    // NOTE: the synchroniser is a small flop array, so every stage is cleared
    // explicitly in the reset branch; it must not be left to power-up state.
    always_ff @(posedge event_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int k = 0; k < SYNC_STAGE; k++) sync_q[k] <= '0;
            in_prev <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the old value
            // of its predecessor, which is what forms the shift chain.
            sync_q[0] <= x_evt_in;
            for (int k = 1; k < SYNC_STAGE; k++) sync_q[k] <= sync_q[k-1];
            in_prev <= x_evt_in_sync;
        end
    end

    assign x_evt_in_sync  = sync_q[SYNC_STAGE-1];
    assign x_evt_in_pulse = x_evt_in_sync & ~in_prev;

    // A new outbound event beats a same-cycle ack on its channel.
    assign out_rise = x_evt_out & ~x_evt_out_ff;

    always_ff @(posedge event_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            x_evt_out_ff   <= '0;
            x_evt_out_pend <= '0;
        end else begin
            x_evt_out_ff   <= x_evt_out;
            x_evt_out_pend <= out_rise | (x_evt_out_pend & ~x_evt_out_ack);
        end
    end

`ifdef HAD_EVT_OVF_DET_EN
    always_ff @(posedge event_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            x_evt_ovf <= '0;
        end else begin
            x_evt_ovf <= (out_rise & x_evt_out_pend & ~x_evt_out_ack)
                       | (x_evt_ovf & ~{CH_NUM{x_ovf_clr}});
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = x_ovf_clr;
    assign x_evt_ovf      = '0;
`endif

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        sync_any = '0;
        for (int k = 0; k < SYNC_STAGE; k++) sync_any = sync_any | sync_q[k];
    end

    // Raw inputs enter combinationally so a first event can restart a stopped clock.
    assign act = |{x_evt_in, sync_any, in_prev, x_evt_out, x_evt_out_ff, x_evt_out_pend};

    always_ff @(posedge event_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            hold_cnt <= '0;
        end else if (act) begin
            hold_cnt <= HOLD_INIT;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 4'd1;
        end
    end

    assign x_event_clk_en = act | (hold_cnt != '0);

endmodule
